branch_resolver: RTL and testbench
==================================

BRANCH_RESOLVER -- requirements
Module: branch_resolver

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 i_rst  input  1  synchronous active-high reset.
REQ-004 i_stall  input  1  freezes IF and ID stages for this cycle.
REQ-005 pc_IF  input  32  PC of the instruction being fetched.
REQ-006 i_pc_sel_BTB  input  1  predictor taken-hit for pc_IF.
REQ-007 i_pred_pc  input  32  predictor target for pc_IF.
REQ-008 pc_EX  input  32  PC of the instruction in EX.
REQ-009 instr_EX  input  32  instruction in EX.
REQ-010 i_taken  input  1  resolved branch outcome in EX.
REQ-011 i_alu_data  input  32  resolved target in EX.
REQ-012 o_redirect_valid  output  1  mispredict detected this cycle; fetch SHALL load o_redirect_pc.
REQ-013 o_redirect_pc  output  32  corrected fetch PC.
REQ-014 o_flush  output  1  kill younger instructions in IF/ID and ID/EX.
REQ-015 o_branch_cnt  output  32  resolved control-transfer count.
REQ-016 o_mispredict_cnt  output  32  mispredict count.

Function
REQ-017 The block SHALL track predictions in a two-entry pipeline (ID, EX), each entry holding {valid, pc, pred_taken, pred_target}.
REQ-018 Each cycle without i_stall, ID SHALL load {1, pc_IF, i_pc_sel_BTB, i_pred_pc}, and EX SHALL load ID.
REQ-019 With i_stall, ID SHALL hold and EX SHALL load valid=0.
REQ-020 When o_flush is high, ID and EX SHALL load valid=0; flush overrides stall.
REQ-021 The EX entry is usable only if valid=1 and entry pc == pc_EX; otherwise pred_taken SHALL be treated as 0.
REQ-022 Control instruction: opcode 1100011 (B), 1101111 (JAL) or 1100111 (JALR); actual_taken = i_taken for B and 1 for JAL/JALR.
REQ-023 For a control instruction, mispredict SHALL be (pred_taken != actual_taken) or (both taken and pred_target != i_alu_data).
REQ-024 For a non-control instruction with usable pred_taken=1, mispredict SHALL be 1 and actual_taken SHALL be treated as 0.
REQ-025 o_redirect_pc SHALL be i_alu_data if actual_taken, else pc_EX+4; it is modulo 2^32, so 0xFFFFFFFC+4 = 0.
REQ-026 o_redirect_valid SHALL equal mispredict combinationally in the detection cycle (0 latency); o_redirect_pc SHALL be 0 when o_redirect_valid=0.
REQ-027 FSM states: IDLE and RECOVER. IDLE->RECOVER on mispredict; RECOVER->IDLE unconditionally after one cycle.
REQ-028 In RECOVER, mispredict detection and counting SHALL be suppressed, and the instruction in EX SHALL be treated as a bubble.
REQ-029 o_flush SHALL be (mispredict in IDLE) or (state==RECOVER), giving exactly two flush cycles per mispredict.
REQ-030 In IDLE, o_branch_cnt SHALL increment by 1 per cycle in which a control instruction is in EX.
REQ-031 o_mispredict_cnt SHALL increment by 1 per mispredict; both counters SHALL saturate at 0xFFFFFFFF.
REQ-032 i_stall SHALL NOT block detection of the instruction currently in EX.

Reset
REQ-033 While i_rst=1 at a rising edge, the block SHALL clear all entry valid bits, set the FSM to IDLE and zero both counters.
REQ-034 In the cycle after reset, o_redirect_valid, o_flush and o_redirect_pc SHALL be 0.
REQ-035 Reset asserted during RECOVER SHALL abort recovery; there SHALL be no flush in the following cycle.

Verification
REQ-036 Predict not-taken at 0x100; two cycles later, B at pc_EX=0x100 with i_taken=1 and i_alu_data=0x200 -> o_redirect_valid=1, o_redirect_pc=0x200, o_flush high for 2 cycles, both counters=1.
REQ-037 Predict taken to 0x180; B resolves taken to 0x200 -> mispredict, redirect to 0x200.
REQ-038 Predict taken to 0x200; B resolves not-taken at pc_EX=0x100 -> redirect to 0x104.
REQ-039 BTB alias: predict taken at 0x40 where instr_EX is ADD -> redirect to 0x44; o_branch_cnt unchanged.
REQ-040 Correct JAL prediction, with i_stall held one cycle before it -> no redirect; bubble not counted; o_branch_cnt=1.
REQ-041 Preload counters near saturation, then a mispredict -> o_mispredict_cnt stays 0xFFFFFFFF; i_rst during RECOVER -> no o_flush the next cycle, counters=0.

Source files
------------

// File: rtl/branch_resolver_if.sv
// branch_resolver_if: fetch-side prediction, EX-side resolution and redirect/flush signals.
// Revision 1.0
`default_nettype none

interface branch_resolver_if;
  logic        i_stall;
  logic [31:0] pc_IF;
  logic        i_pc_sel_BTB;
  logic [31:0] i_pred_pc;
  logic [31:0] pc_EX;
  logic [31:0] instr_EX;
  logic        i_taken;
  logic [31:0] i_alu_data;
  logic        o_redirect_valid;
  logic [31:0] o_redirect_pc;
  logic        o_flush;
  logic [31:0] o_branch_cnt;
  logic [31:0] o_mispredict_cnt;

  modport master (
    output i_stall, pc_IF, i_pc_sel_BTB, i_pred_pc, pc_EX, instr_EX, i_taken, i_alu_data,
    input  o_redirect_valid, o_redirect_pc, o_flush, o_branch_cnt, o_mispredict_cnt
  );

  modport slave (
    input  i_stall, pc_IF, i_pc_sel_BTB, i_pred_pc, pc_EX, instr_EX, i_taken, i_alu_data,
    output o_redirect_valid, o_redirect_pc, o_flush, o_branch_cnt, o_mispredict_cnt
  );
endinterface

`default_nettype wire

// File: rtl/branch_resolver.sv
// branch_resolver: compares carried predictions with EX resolution, redirects fetch and flushes.
// Revision 1.0
`default_nettype none

module branch_resolver (
  input  logic             i_clk,
  input  logic             i_rst,
  branch_resolver_if.slave bus
);

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [0:0] {IDLE = 1'b0, RECOVER = 1'b1} state_t;

  state_t      state, next_state;

  logic        id_valid, id_pred_taken;
  logic [31:0] id_pc, id_pred_target;
  logic        ex_valid, ex_pred_taken;
  logic [31:0] ex_pc, ex_pred_target;

  logic [31:0] branch_cnt, mispredict_cnt;

  logic [6:0]  opcode;
  logic        is_branch, is_ctrl;
  logic        pred_taken, actual_taken;
  logic        mispredict_raw, mispredict;
  logic        flush;
  logic        count_branch;
  logic [31:0] redirect_pc;
  logic        unused_instr_bits;

  assign unused_instr_bits = ^bus.instr_EX[31:7];

  always_comb begin
    next_state     = state;
    opcode         = bus.instr_EX[6:0];
    is_branch      = (opcode == OP_BRANCH);
    is_ctrl        = is_branch || (opcode == OP_JAL) || (opcode == OP_JALR);
    // A stale or aliased EX entry must not be trusted as a prediction
    pred_taken     = ex_valid && (ex_pc == bus.pc_EX) && ex_pred_taken;
    actual_taken   = 1'b0;
    mispredict_raw = 1'b0;
    if (is_ctrl) begin
      actual_taken   = is_branch ? bus.i_taken : 1'b1;
      mispredict_raw = (pred_taken != actual_taken) ||
                       (pred_taken && actual_taken && (ex_pred_target != bus.i_alu_data));
    end else begin
      mispredict_raw = pred_taken;
    end
    mispredict   = 1'b0;
    count_branch = 1'b0;
    flush        = 1'b0;
    case (state)
      IDLE: begin
        mispredict   = mispredict_raw;
        count_branch = is_ctrl;
        flush        = mispredict_raw;
        if (mispredict_raw) next_state = RECOVER;
      end
      RECOVER: begin
        flush      = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    redirect_pc = 32'h0;
    if (mispredict) redirect_pc = actual_taken ? bus.i_alu_data : bus.pc_EX + 32'd4;
  end

  assign bus.o_redirect_valid = mispredict;
  assign bus.o_redirect_pc    = redirect_pc;
  assign bus.o_flush          = flush;
  assign bus.o_branch_cnt     = branch_cnt;
  assign bus.o_mispredict_cnt = mispredict_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= next_state;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      id_valid <= 1'b0;
      ex_valid <= 1'b0;
    end else if (flush) begin
      id_valid <= 1'b0;
      ex_valid <= 1'b0;
    end else if (bus.i_stall) begin
      ex_valid <= 1'b0;
    end else begin
      id_valid       <= 1'b1;
      id_pc          <= bus.pc_IF;
      id_pred_taken  <= bus.i_pc_sel_BTB;
      id_pred_target <= bus.i_pred_pc;
      ex_valid       <= id_valid;
      ex_pc          <= id_pc;
      ex_pred_taken  <= id_pred_taken;
      ex_pred_target <= id_pred_target;
    end
  end

  // Counters are only written on an increment so they stick at all-ones
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      branch_cnt     <= 32'h0;
      mispredict_cnt <= 32'h0;
    end else begin
      if (count_branch && (branch_cnt != 32'hFFFF_FFFF))
        branch_cnt <= branch_cnt + 32'd1;
      if (mispredict && (mispredict_cnt != 32'hFFFF_FFFF))
        mispredict_cnt <= mispredict_cnt + 32'd1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_branch_resolver.sv
// tb_branch_resolver: directed vectors for branch_resolver with hand-computed expectations.
// Revision 1.0
`default_nettype none

module tb_branch_resolver;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] BEQ  = 32'h0020_8463;
  localparam logic [31:0] JAL  = 32'h0080_006F;
  localparam logic [31:0] ADD  = 32'h0020_8033;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  branch_resolver_if bus ();

  branch_resolver dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_if(input logic [31:0] pc, input logic sel, input logic [31:0] tgt);
    bus.pc_IF        = pc;
    bus.i_pc_sel_BTB = sel;
    bus.i_pred_pc    = tgt;
  endtask

  task automatic set_ex(input logic [31:0] pc, input logic [31:0] instr,
                        input logic taken, input logic [31:0] alu);
    bus.pc_EX      = pc;
    bus.instr_EX   = instr;
    bus.i_taken    = taken;
    bus.i_alu_data = alu;
  endtask

  // Fetch pc with a prediction, let it travel to EX and present its resolution
  task automatic run_pipe(input logic [31:0] pc, input logic sel, input logic [31:0] tgt,
                          input logic [31:0] instr, input logic taken, input logic [31:0] alu);
    set_if(pc, sel, tgt);
    set_ex(32'h0, NOP, 1'b0, 32'h0);
    tick();
    set_if(pc + 32'd4, 1'b0, 32'h0);
    tick();
    set_if(pc + 32'd8, 1'b0, 32'h0);
    set_ex(pc, instr, taken, alu);
    #1;
  endtask

  task automatic recover(input string tag, input logic [31:0] exp_b, input logic [31:0] exp_m);
    tick();
    set_ex(32'h0, NOP, 1'b0, 32'h0);
    set_if(32'h500, 1'b0, 32'h0);
    #1;
    chk({tag, "_rec_flush"}, {31'h0, bus.o_flush}, 32'h1);
    chk({tag, "_rec_rv"}, {31'h0, bus.o_redirect_valid}, 32'h0);
    chk({tag, "_rec_rpc"}, bus.o_redirect_pc, 32'h0);
    chk({tag, "_bcnt"}, bus.o_branch_cnt, exp_b);
    chk({tag, "_mcnt"}, bus.o_mispredict_cnt, exp_m);
    tick();
    #1;
    chk({tag, "_idle_flush"}, {31'h0, bus.o_flush}, 32'h0);
  endtask

  initial begin
    rst         = 1'b1;
    bus.i_stall = 1'b0;
    set_if(32'h500, 1'b0, 32'h0);
    set_ex(32'h0, NOP, 1'b0, 32'h0);
    @(negedge clk);
    tick();
    rst = 1'b0;
    #1;
    chk("rst_rv", {31'h0, bus.o_redirect_valid}, 32'h0);
    chk("rst_flush", {31'h0, bus.o_flush}, 32'h0);
    chk("rst_rpc", bus.o_redirect_pc, 32'h0);
    chk("rst_bcnt", bus.o_branch_cnt, 32'h0);
    chk("rst_mcnt", bus.o_mispredict_cnt, 32'h0);

    // Predicted not-taken, resolved taken
    run_pipe(32'h100, 1'b0, 32'h0, BEQ, 1'b1, 32'h200);
    chk("nt_tk_rv", {31'h0, bus.o_redirect_valid}, 32'h1);
    chk("nt_tk_rpc", bus.o_redirect_pc, 32'h200);
    chk("nt_tk_flush", {31'h0, bus.o_flush}, 32'h1);
    recover("nt_tk", 32'd1, 32'd1);

    // Predicted taken to the wrong target
    run_pipe(32'h100, 1'b1, 32'h180, BEQ, 1'b1, 32'h200);
    chk("tgt_rv", {31'h0, bus.o_redirect_valid}, 32'h1);
    chk("tgt_rpc", bus.o_redirect_pc, 32'h200);
    recover("tgt", 32'd2, 32'd2);

    // Predicted taken, resolved not-taken: fall through
    run_pipe(32'h100, 1'b1, 32'h200, BEQ, 1'b0, 32'h200);
    chk("tk_nt_rv", {31'h0, bus.o_redirect_valid}, 32'h1);
    chk("tk_nt_rpc", bus.o_redirect_pc, 32'h104);
    recover("tk_nt", 32'd3, 32'd3);

    // BTB alias on a non-control instruction
    run_pipe(32'h40, 1'b1, 32'h80, ADD, 1'b0, 32'h1234);
    chk("alias_rv", {31'h0, bus.o_redirect_valid}, 32'h1);
    chk("alias_rpc", bus.o_redirect_pc, 32'h44);
    recover("alias", 32'd3, 32'd4);

    // Correct JAL prediction with a stall ahead of it
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_if(32'h300, 1'b1, 32'h400);
    set_ex(32'h0, NOP, 1'b0, 32'h0);
    tick();
    bus.i_stall = 1'b1;
    set_if(32'h304, 1'b0, 32'h0);
    tick();
    bus.i_stall = 1'b0;
    #1;
    chk("stall_bubble_rv", {31'h0, bus.o_redirect_valid}, 32'h0);
    chk("stall_bubble_bcnt", bus.o_branch_cnt, 32'h0);
    tick();
    set_ex(32'h300, JAL, 1'b1, 32'h400);
    set_if(32'h308, 1'b0, 32'h0);
    #1;
    chk("jal_rv", {31'h0, bus.o_redirect_valid}, 32'h0);
    chk("jal_flush", {31'h0, bus.o_flush}, 32'h0);
    chk("jal_rpc", bus.o_redirect_pc, 32'h0);
    tick();
    chk("jal_bcnt", bus.o_branch_cnt, 32'd1);
    chk("jal_mcnt", bus.o_mispredict_cnt, 32'd0);

    // Saturation, then reset while recovering
    set_ex(32'h0, NOP, 1'b0, 32'h0);
    force dut.branch_cnt = 32'hFFFF_FFFF;
    force dut.mispredict_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.branch_cnt;
    release dut.mispredict_cnt;
    run_pipe(32'hFFFF_FFF0, 1'b0, 32'h0, BEQ, 1'b0, 32'h0);
    run_pipe(32'h100, 1'b0, 32'h0, BEQ, 1'b1, 32'h200);
    chk("sat_rv", {31'h0, bus.o_redirect_valid}, 32'h1);
    tick();
    set_ex(32'h0, NOP, 1'b0, 32'h0);
    #1;
    chk("sat_bcnt", bus.o_branch_cnt, 32'hFFFF_FFFF);
    chk("sat_mcnt", bus.o_mispredict_cnt, 32'hFFFF_FFFF);
    chk("sat_rec_flush", {31'h0, bus.o_flush}, 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("abort_flush", {31'h0, bus.o_flush}, 32'h0);
    chk("abort_rv", {31'h0, bus.o_redirect_valid}, 32'h0);
    chk("abort_bcnt", bus.o_branch_cnt, 32'h0);
    chk("abort_mcnt", bus.o_mispredict_cnt, 32'h0);

    // Fall-through address wraps at the top of the address space
    run_pipe(32'hFFFF_FFFC, 1'b1, 32'h80, BEQ, 1'b0, 32'h0);
    chk("wrap_rv", {31'h0, bus.o_redirect_valid}, 32'h1);
    chk("wrap_rpc", bus.o_redirect_pc, 32'h0);
    recover("wrap", 32'd1, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
